// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency next-PC prediction, trained by ID-stage resolution; keeps saturating miss statistics.
module branch_predictor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRY_NUM  = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_addr,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_pred_taken,
  input  logic [ADDR_WIDTH-1:0] update_pred_target,
  input  logic                  flush,
  output logic                  mispredict,
  output logic [CNT_WIDTH-1:0]  lookup_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int unsigned INDEX_WIDTH = $clog2(ENTRY_NUM);
  localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2;

  logic [ENTRY_NUM-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];
  logic [1:0]            ctr_q    [ENTRY_NUM];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit;
  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   up_hit;
  logic                   unused_low_bits;

  assign lk_idx = lookup_addr[INDEX_WIDTH+1:2];
  assign lk_tag = lookup_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign up_idx = update_addr[INDEX_WIDTH+1:2];
  assign up_tag = update_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_low_bits = ^{lookup_addr[1:0], update_addr[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not visible.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_addr + ADDR_WIDTH'(4);
  end

  always_comb begin
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    mispredict = update_valid &&
                 ((update_pred_taken != update_taken) ||
                  (update_taken && (update_pred_target != update_target)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          ctr_q[up_idx]    <= (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= update_target;
        end else begin
          ctr_q[up_idx] <= (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Statistics ignore flush and saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_valid && (lookup_count != '1)) begin
        lookup_count <= lookup_count + CNT_WIDTH'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits beside the IF stage: each cycle it predicts the next fetch PC for the current fetch address.
- It is trained by the ID-stage branch resolution (branch flag and target) one or more cycles later.
- Successor to the purely combinational branch resolver: adds state, training, flush and misprediction statistics.

Parameters:
- ADDR_WIDTH, 32, fetch/target address width in bits.
- ENTRY_NUM, 64, BTB entries; must be a power of two and at least 2.
- INDEX_WIDTH, log2(ENTRY_NUM), derived; index bits.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-2, derived; tag bits.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- lookup_addr  in  ADDR_WIDTH  current IF fetch address, word-aligned.
- pred_taken  out  1  predicted taken (combinational from table state).
- pred_target  out  ADDR_WIDTH  predicted next PC.
- update_valid  in  1  a resolved control-transfer instruction is presented this cycle.
- update_addr  in  ADDR_WIDTH  address of the resolved instruction.
- update_taken  in  1  actual branch flag from ID.
- update_target  in  ADDR_WIDTH  actual branch address from ID.
- update_pred_taken  in  1  prediction that was issued for this instruction.
- update_pred_target  in  ADDR_WIDTH  target that was issued for this instruction.
- flush  in  1  synchronous invalidate of all entries.
- mispredict  out  1  combinational; high when the current update was mispredicted.
- lookup_count  out  CNT_WIDTH  registered count of resolved updates.
- mispredict_count  out  CNT_WIDTH  registered count of mispredictions.

Behaviour:
- Address split:
  - index = addr[INDEX_WIDTH+1:2]
  - tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2]
  - addr[1:0] ignored.
- Entry state: valid (1 bit), tag, target (ADDR_WIDTH), ctr (2 bits).
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = entry target when pred_taken, else lookup_addr+4 (mod 2^ADDR_WIDTH).
- mispredict definition:
  - mispredict = update_valid & ((update_pred_taken != update_taken) | (update_taken & update_pred_target != update_target)).
  - Not-taken with a wrong stale target is NOT a mispredict.
- Update (registered on rising clk when update_valid=1):
  - Hit, taken: ctr saturating increment (11 stays 11); target <= update_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace; valid=1, tag, target=update_target, ctr=2'b10.
  - Miss, not taken: no table change.
- Statistics:
  - lookup_count += 1 per update_valid cycle.
  - mispredict_count += 1 per mispredict cycle.
  - Both saturate at all-ones; never wrap.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state; no write-through bypass.
- flush: all valid <= 0 and ctr <= 2'b01 next edge. flush has priority over a simultaneous update, which is dropped. Statistics are unaffected by flush, but a mispredict in the flush cycle is still counted.
- Reset (rst=0, asynchronous): all valid=0, ctr=2'b01, tags/targets=0, both counters=0.
  - Hence pred_taken=0 and pred_target=lookup_addr+4 during and after reset.
  - Reset mid-operation discards any pending update.
- No stall input: the upstream drives update_valid exactly once per resolved branch/jump.

Test Plan:
- After reset, lookup_addr=0x00400010 -> pred_taken=0, pred_target=0x00400014; both counters=0.
- Update addr=0x00400020, taken=1, target=0x00400100, pred_taken=0 -> mispredict=1. Next cycle: lookup 0x00400020 gives pred_taken=1 (ctr=10), target 0x00400100; mispredict_count=1, lookup_count=1.
- Same entry, 3 taken updates then 3 not-taken updates -> ctr sequence 11,11,11,10,01,00. pred_taken goes 0 from the 5th update on; a subsequent taken update gives ctr=01 and pred_taken=0.
- Aliasing, ENTRY_NUM=64: allocate 0x00400020, then taken update at 0x00400120 (same index, different tag) -> replaced. Lookup 0x00400020 misses, returns +4.
- flush asserted together with a taken update to a new address -> next cycle all lookups miss; the entry is not allocated; lookup_count still increments.
- Force mispredict_count to all-ones (CNT_WIDTH=4 build, 16 mispredictions) -> value holds at 4'hF. Assert rst low mid-cycle -> all outputs reset immediately, without waiting for a clock edge.
